serial_subtractor: RTL and testbench

//   Bit-serial subtractor: computes Diff = A - B - Bin one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Operands are captured on start; Diff/Bout update only at the RUN->DONE edge.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               br_q,     br_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               bout_q,   bout_d;

    logic               d_bit;
    logic               br_next;
    logic [WIDTH-1:0]   res_next;

    // One full-subtractor slice on the current LSBs of the shift registers.
    assign d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    assign br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    assign res_next = {d_bit, res_sh_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    br_d     = Bin;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next;
                br_d     = br_next;
                cnt_d    = cnt_q + 1'b1;
                // Last bit: publish the completed word so no partial result is ever visible.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = res_next;
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected {Bout,Diff} pushed at start,
// popped and compared in the done cycle.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         bout_o;

    int n_vec;
    int n_err;

    logic [W:0] sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .busy  (busy_o),
        .done  (done_o),
        .Diff  (diff_o),
        .Bout  (bout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    endfunction

    // Drive one request so that it is sampled at the next rising edge; leaves time #1 after it.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; bin = c; start = 1'b1;
        sb.push_back(ref_sub(x, y, c));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the start edge until done, then measures the done pulse width.
    task automatic wait_done(output int lat, output logic [W-1:0] d, output logic bo,
                             output int len, output bit to);
        lat = 0; len = 0; to = 1'b0; d = '0; bo = 1'b0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!done_o && lat < 40);
        if (!done_o) begin
            to = 1'b1;
            return;
        end
        d  = diff_o;
        bo = bout_o;
        while (done_o && len < 10) begin
            len++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy_o, done_o, bout_o, diff_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b bout=%b diff=%h, want all 0",
                     busy_o, done_o, bout_o, diff_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Table-driven ops with latency and done-width checks.
    task automatic test_table(input string tag, input logic [W-1:0] ta[],
                              input logic [W-1:0] tb_[], input logic tc[]);
        int lat, len; bit to; logic [W-1:0] d; logic bo; logic [W:0] exp;
        foreach (ta[i]) begin
            issue(ta[i], tb_[i], tc[i]);
            wait_done(lat, d, bo, len, to);
            exp = sb.pop_front();
            n_vec++;
            if (to) begin
                n_err++;
                $display("FAIL %s[%0d]_timeout: no done within 40 edges", tag, i);
                continue;
            end
            if ({bo, d} !== exp) begin
                n_err++;
                $display("FAIL %s[%0d]_result: got bout=%b diff=%h, want bout=%b diff=%h",
                         tag, i, bo, d, exp[W], exp[W-1:0]);
            end
            n_vec++;
            if (lat != W) begin
                n_err++;
                $display("FAIL %s[%0d]_latency: done %0d edges after start edge, want %0d",
                         tag, i, lat, W);
            end
            n_vec++;
            if (len != 1) begin
                n_err++;
                $display("FAIL %s[%0d]_done_width: done high %0d cycles, want 1", tag, i, len);
            end
        end
    endtask

    task automatic test_basic;
        test_table("basic", '{4'd5, 4'd2, 4'd9}, '{4'd3, 4'd4, 4'd7}, '{1'b0, 1'b1, 1'b1});
    endtask

    task automatic test_boundaries;
        test_table("bound", '{4'd0, 4'd15, 4'd7}, '{4'd15, 4'd0, 4'd7}, '{1'b1, 1'b0, 1'b1});
    endtask

    // start held high through RUN/DONE with operands churning; only the captured op counts.
    task automatic test_busy_done;
        int dones, lat, len; bit to; logic [W-1:0] d, first_d; logic bo; logic [W:0] exp;
        dones = 0; first_d = '0; bo = 1'b0;
        @(negedge clk);
        a = 4'd5; b = 4'd3; bin = 1'b0; start = 1'b1;
        sb.push_back(ref_sub(4'd5, 4'd3, 1'b0));
        @(posedge clk); #1;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL hold_busy: got busy=%b, want 1", busy_o);
        end
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                dones++;
                first_d = diff_o;
                bo = bout_o;
            end
        end
        exp = sb.pop_front();
        n_vec++;
        if ({bo, first_d} !== exp) begin
            n_err++;
            $display("FAIL hold_result: got bout=%b diff=%h, want bout=%b diff=%h",
                     bo, first_d, exp[W], exp[W-1:0]);
        end
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL hold_done_count: got %0d done cycles, want 1", dones);
        end
        // Now in IDLE with start still high: the next edge must accept a new op.
        @(negedge clk);
        a = 4'd9; b = 4'd7; bin = 1'b1;
        sb.push_back(ref_sub(4'd9, 4'd7, 1'b1));
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL next_accept: got busy=%b, want 1", busy_o);
        end
        n_vec++;
        if (diff_o !== exp[W-1:0]) begin
            n_err++;
            $display("FAIL diff_hold: got diff=%h, want %h", diff_o, exp[W-1:0]);
        end
        wait_done(lat, d, bo, len, to);
        exp = sb.pop_front();
        n_vec++;
        if (to || {bo, d} !== exp || lat != W || len != 1) begin
            n_err++;
            $display("FAIL second_op: got to=%b bout=%b diff=%h lat=%0d len=%0d, want bout=%b diff=%h lat=%0d len=1",
                     to, bo, d, lat, len, exp[W], exp[W-1:0], W);
        end
    endtask

    task automatic test_mid_reset;
        int dones; logic [W:0] dropped;
        issue(4'd12, 4'd3, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy_o, done_o, bout_o, diff_o} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b done=%b bout=%b diff=%h, want all 0",
                     busy_o, done_o, bout_o, diff_o);
        end
        dropped = sb.pop_front();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk); #1;
            if (done_o !== 1'b0) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d done cycles (dropped op %h), want 0",
                     dones, dropped);
        end
        test_table("post_reset", '{4'd6}, '{4'd8}, '{1'b1});
    endtask

    task automatic test_exhaustive;
        int lat, len, bad; bit to; logic [W-1:0] d; logic bo; logic [W:0] exp;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            issue(W'(i >> 5), W'(i >> 1), 1'(i));
            wait_done(lat, d, bo, len, to);
            exp = sb.pop_front();
            n_vec++;
            if (to || {bo, d} !== exp || len != 1) begin
                n_err++;
                bad++;
                if (bad <= 10)
                    $display("FAIL exh A=%0d B=%0d Bin=%0d: got to=%b bout=%b diff=%h len=%0d, want bout=%b diff=%h len=1",
                             i >> 5, (i >> 1) & 15, i & 1, to, bo, d, len, exp[W], exp[W-1:0]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_busy_done();
        test_mid_reset();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
